// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC bit-slip alignment block.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    localparam logic [15:0] TRAIN_PATTERN_DEF = 16'hF0A5;

    function automatic logic is_busy(input state_e s);
        return (s == ST_SETTLE) || (s == ST_CHECK) || (s == ST_SLIP);
    endfunction

endpackage

// File: rtl/adc_bitslip_align_if.sv
// Control/status bundle between the alignment FSM and its host/deserializer.
interface adc_bitslip_align_if;

    logic        start;
    logic [15:0] d_in;
    logic        bitslip;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [2:0]  slip_count;

    modport master (
        output start, d_in,
        input  bitslip, busy, locked, fail, slip_count
    );

    modport slave (
        input  start, d_in,
        output bitslip, busy, locked, fail, slip_count
    );

endinterface

// File: rtl/adc_bitslip_align.sv
// Word-alignment FSM: slips both lane deserializers until the training
// pattern is seen MATCH_COUNT times in a row, or gives up after MAX_SLIPS.
module adc_bitslip_align
    import adc_pkg::*;
#(
    parameter logic [15:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          MATCH_COUNT   = 16,
    parameter int          MAX_SLIPS     = 7
) (
    input  logic                CLKDIV,
    input  logic                RST_N,
    adc_bitslip_align_if.slave  bus
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
    localparam int SLIP_W   = $clog2(MAX_SLIPS + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic                bitslip_q, busy_q, locked_q, fail_q;
    logic                pattern_hit_s;

    assign pattern_hit_s = (bus.d_in == TRAIN_PATTERN);

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        slip_d   = slip_q;
        case (state_q)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (bus.start) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                    match_d  = '0;
                    slip_d   = '0;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_CHECK;
                    settle_d = '0;
                    match_d  = '0;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_CHECK: begin
                if (pattern_hit_s) begin
                    if (match_q == MATCH_LAST) begin
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end else begin
                    // Any mismatch throws away the run of good words.
                    match_d = '0;
                    if (slip_q < SLIP_MAX) begin
                        state_d = ST_SLIP;
                        slip_d  = slip_q + SLIP_W'(1);
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_SLIP: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs decode the next state
    // so they line up with the state register.
    always_ff @(posedge CLKDIV) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            match_q   <= '0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            busy_q    <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            slip_q    <= slip_d;
            bitslip_q <= (state_d == ST_SLIP);
            busy_q    <= is_busy(state_d);
            locked_q  <= (state_d == ST_LOCKED);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign bus.bitslip    = bitslip_q;
    assign bus.busy       = busy_q;
    assign bus.locked     = locked_q;
    assign bus.fail       = fail_q;
    assign bus.slip_count = 3'(slip_q);

endmodule

// File: tb/tb_adc_bitslip_align.sv
// Directed bench for adc_bitslip_align: aligned, misaligned, never-matching,
// glitch, re-lock and reset-during-slip scenarios.
module tb_adc_bitslip_align;
    import adc_pkg::*;

    localparam logic [15:0] PAT = 16'hF0A5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_bitslip_align_if bus ();

    adc_bitslip_align #(
        .TRAIN_PATTERN (PAT),
        .SETTLE_CYCLES (8),
        .MATCH_COUNT   (16),
        .MAX_SLIPS     (7)
    ) dut (
        .CLKDIV (clk),
        .RST_N  (rst_n),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, pulses, last_pulse, first_pulse, min_gap;
    int mode;          // 0 constant d_in, 1 rotating lane model, 2 single glitch
    int rot_target;
    int glitch_at;
    int done_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rot_word(input int k);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'hF0;
        b = 8'hA5;
        if (k != 0) begin
            a = (a << k) | (a >> (8 - k));
            b = (b << k) | (b >> (8 - k));
        end
        return {a, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.bitslip) begin
            if (pulses == 0) first_pulse = cyc;
            else if (cyc - last_pulse - 1 < min_gap) min_gap = cyc - last_pulse - 1;
            last_pulse = cyc;
            pulses++;
        end
        if (mode == 1) begin
            bus.d_in = rot_word((pulses >= rot_target) ? 0 : (rot_target - pulses));
        end else if (mode == 2) begin
            bus.d_in = (cyc == glitch_at - 1) ? 16'h0000 : PAT;
        end else begin
            bus.d_in = bus.d_in;
        end
    endtask

    task automatic start_training();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        cyc         = 0;
        pulses      = 0;
        last_pulse  = 0;
        first_pulse = 0;
        min_gap     = 1000;
    endtask

    task automatic run_until_done(input int budget);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.locked || bus.fail) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.d_in  = 16'h0000;
        mode      = 0;
        rot_target = 0;
        glitch_at  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bitslip", 32'(bus.bitslip), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_fail", 32'(bus.fail), 32'd0);
        check("rst_slip_count", 32'(bus.slip_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Aligned input: lock 8 + 16 cycles after the start edge.
        mode = 0;
        bus.d_in = PAT;
        start_training();
        check("aligned_busy_after_start", 32'(bus.busy), 32'd1);
        run_until_done(200);
        check("aligned_lock_cycle", 32'(done_cyc), 32'd24);
        check("aligned_locked", 32'(bus.locked), 32'd1);
        check("aligned_pulses", 32'(pulses), 32'd0);
        check("aligned_slip_count", 32'(bus.slip_count), 32'd0);
        check("aligned_busy", 32'(bus.busy), 32'd0);

        // Misaligned by 3: three rounds of 10 cycles then 24 to lock.
        mode = 1;
        rot_target = 3;
        bus.d_in = rot_word(3);
        start_training();
        run_until_done(400);
        check("mis3_lock_cycle", 32'(done_cyc), 32'd54);
        check("mis3_pulses", 32'(pulses), 32'd3);
        check("mis3_gap_ge9", 32'(min_gap >= 9), 32'd1);
        check("mis3_locked", 32'(bus.locked), 32'd1);
        check("mis3_slip_count", 32'(bus.slip_count), 32'd3);

        // Never matching: seven slips then FAIL.
        mode = 0;
        bus.d_in = 16'h0000;
        start_training();
        run_until_done(400);
        check("never_fail_cycle", 32'(done_cyc), 32'd79);
        check("never_pulses", 32'(pulses), 32'd7);
        check("never_fail", 32'(bus.fail), 32'd1);
        check("never_locked", 32'(bus.locked), 32'd0);
        check("never_busy", 32'(bus.busy), 32'd0);
        check("never_slip_count", 32'(bus.slip_count), 32'd7);
        repeat (5) step();
        check("fail_holds", 32'(bus.fail), 32'd1);
        check("fail_slip_count_holds", 32'(bus.slip_count), 32'd7);

        // Glitch on the 16th compared word: one slip, count restarts.
        mode = 2;
        glitch_at = 24;
        bus.d_in = PAT;
        start_training();
        check("glitch_fail_cleared", 32'(bus.fail), 32'd0);
        run_until_done(400);
        check("glitch_lock_cycle", 32'(done_cyc), 32'd49);
        check("glitch_first_pulse", 32'(first_pulse), 32'd24);
        check("glitch_pulses", 32'(pulses), 32'd1);
        check("glitch_slip_count", 32'(bus.slip_count), 32'd1);

        // Re-lock from LOCKED with the pattern present.
        mode = 0;
        bus.d_in = PAT;
        start_training();
        check("relock_busy", 32'(bus.busy), 32'd1);
        check("relock_unlocked", 32'(bus.locked), 32'd0);
        check("relock_slip_cleared", 32'(bus.slip_count), 32'd0);
        run_until_done(200);
        check("relock_cycle", 32'(done_cyc), 32'd24);
        check("relock_slip_count", 32'(bus.slip_count), 32'd0);

        // Start while busy is ignored; reset during SLIP aborts cleanly.
        mode = 0;
        bus.d_in = 16'h0000;
        start_training();
        step();
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.bitslip) break;
            step();
        end
        check("busy_start_first_pulse", 32'(first_pulse), 32'd9);
        check("in_slip_bitslip", 32'(bus.bitslip), 32'd1);
        rst_n = 1'b0;
        step();
        check("slip_rst_bitslip", 32'(bus.bitslip), 32'd0);
        check("slip_rst_busy", 32'(bus.busy), 32'd0);
        check("slip_rst_locked", 32'(bus.locked), 32'd0);
        check("slip_rst_fail", 32'(bus.fail), 32'd0);
        check("slip_rst_slip_count", 32'(bus.slip_count), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) step();
        check("post_rst_no_pulse", 32'(pulses), 32'd0);
        check("post_rst_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_bitslip_align.md
ADC_BITSLIP_ALIGN -- requirements
Module: adc_bitslip_align

Interface
REQ-001 Parameter TRAIN_PATTERN, 16'hF0A5: expected deserialized word during ADC test-pattern mode.
REQ-002 Parameter SETTLE_CYCLES, 8: CLKDIV cycles to wait after start or after a slip before comparing.
REQ-003 Parameter MATCH_COUNT, 16: consecutive matching words required to declare lock.
REQ-004 Parameter MAX_SLIPS, 7: slips permitted before declaring failure (8 bit positions for 1:8 deserialization).
REQ-005 CLKDIV  input  1  sole clock; all logic is on its rising edge.
REQ-006 RST_N  input  1  synchronous, active-low reset.
REQ-007 start  input  1  request (re)training; sampled only in IDLE, LOCKED or FAIL.
REQ-008 d_in  input  16  interleaved two-lane deserialized word from the deserializer stage.
REQ-009 bitslip  output  1  registered one-cycle pulse to both lane deserializers.
REQ-010 busy  output  1  high in SETTLE, CHECK and SLIP.
REQ-011 locked  output  1  high in LOCKED only.
REQ-012 fail  output  1  high in FAIL only.
REQ-013 slip_count  output  3  number of slips issued since the last start.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, CHECK, SLIP, LOCKED and FAIL.
REQ-015 IDLE, LOCKED and FAIL with start=1 SHALL go to SETTLE, clearing slip_count, the settle counter and the match counter.
REQ-016 start in SETTLE, CHECK or SLIP SHALL be ignored.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK with the match counter at 0.
REQ-018 CHECK SHALL compare d_in to TRAIN_PATTERN every cycle (unregistered compare, full 16 bits).
REQ-019 In CHECK, a match SHALL increment the match counter; the MATCH_COUNT-th consecutive match SHALL go to LOCKED on the same edge.
REQ-020 In CHECK, a mismatch with slip_count < MAX_SLIPS SHALL go to SLIP.
REQ-021 In CHECK, a mismatch with slip_count == MAX_SLIPS SHALL go to FAIL.
REQ-022 SLIP SHALL last one cycle, during which bitslip is 1 and slip_count increments; it then goes to SETTLE.
REQ-023 bitslip SHALL be 0 in every state other than SLIP; two bitslip pulses are separated by at least SETTLE_CYCLES+1 low cycles.
REQ-024 LOCKED and FAIL SHALL hold until start or reset; d_in is ignored there, since normal ADC data no longer matches the pattern.
REQ-025 slip_count SHALL saturate at MAX_SLIPS and hold its value in LOCKED and FAIL for debug.
REQ-026 Fastest lock (no slips) SHALL occur SETTLE_CYCLES+MATCH_COUNT cycles after the start-sampling edge.
REQ-027 A mismatch on any match-counter value (including MATCH_COUNT-1) SHALL discard progress.

Reset
REQ-028 With RST_N=0 at a clock edge, the block SHALL enter IDLE and clear all counters.
REQ-029 Reset SHALL set bitslip=0, busy=0, locked=0, fail=0 and slip_count=0.
REQ-030 Reset mid-training (including during SLIP) SHALL abort with no further bitslip pulse.

Structure
REQ-031 Shared package adc_pkg SHALL hold the state enum type and the default training-pattern constant.
REQ-032 Counter widths SHALL be derived with $clog2 from the parameters.
REQ-033 No sub-module is needed; the block is a single FSM with three counters (settle, match, slip).

Verification
REQ-034 Aligned input: d_in=16'hF0A5 constantly, pulse start -> no bitslip pulse; locked=1 exactly 24 cycles after the start edge; slip_count=0.
REQ-035 Misaligned by 3: the deserializer model rotates lanes until 3 slips are applied -> exactly 3 bitslip pulses, each 9+ cycles apart; then locked=1 and slip_count=3.
REQ-036 Never-matching input 16'h0000 -> exactly 7 bitslip pulses, then fail=1 with slip_count=7 and busy=0.
REQ-037 Glitch: 15 matches, 1 mismatch, then continuous matches -> one slip issued and counting restarts; lock is not declared early.
REQ-038 RST_N=0 for 1 cycle while in SLIP -> bitslip=0 on the next cycle, IDLE entered, all outputs at reset values; start while busy has no effect.
REQ-039 From LOCKED, pulse start with the pattern present -> busy=1, locked=0, then re-lock after 24 cycles with slip_count=0.
